// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, FSM state and buffer entry types for the fetch front end
package fetch_pkg;
    localparam int XLEN_D = 64;
    localparam int ILEN_D = 32;
    localparam logic [63:0] RESET_PC_D = 64'h400000;
    typedef enum logic {IDLE, REQ} fetch_state_e;
    typedef struct packed {
        logic [XLEN_D-1:0] pc;
        logic [ILEN_D-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush taking priority over push and pop
module fetch_fifo #(
    parameter int W = 96,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            wr <= push ? wr + AW'(1) : wr;
            rd <= pop ? rd + AW'(1) : rd;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr] <= din;
    end
    // An empty buffer presents zeros rather than stale storage.
    assign head = count != '0 ? mem[rd] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: icache request sequencer feeding a flushable instruction buffer towards decode
module fetch_unit import fetch_pkg::*; #(
    parameter int XLEN = XLEN_D,
    parameter int ILEN = ILEN_D,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_D)
) (
    input  logic clk,
    input  logic rst,
    output logic icache_rqst,
    output logic [XLEN-1:0] icache_addr,
    input  logic icache_done,
    input  logic [XLEN-1:0] icache_data,
    input  logic redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic out_valid,
    input  logic out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] pc
);
    localparam int OFF = $clog2(ILEN/8);
    localparam int NW = XLEN/ILEN;
    localparam int SW = NW > 1 ? $clog2(NW) : 1;
    localparam int CW = $clog2(DEPTH)+1;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;
    fetch_state_e state, state_next;
    logic [XLEN-1:0] pc_next;
    logic discard, discard_next, done, hold, push, pop;
    logic [CW-1:0] count, count_next;
    logic [SW-1:0] sel;
    entry_t din, head;
    always_comb begin
        done = state == REQ && icache_done;
        hold = state == REQ && !icache_done;
        pop = out_valid && out_ready;
        push = done && !discard && !redirect_valid;
        count_next = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        pc_next = redirect_valid ? redirect_pc & ~XLEN'(ILEN/8-1)
                : (done && !discard) ? pc + XLEN'(ILEN/8) : pc;
        discard_next = (hold && redirect_valid) ? 1'b1 : done ? 1'b0 : discard;
        // The in-flight request owns a slot, so only issue while one is free.
        state_next = (hold || count_next < CW'(DEPTH)) ? REQ : IDLE;
        sel = NW > 1 ? SW'(icache_addr >> OFF) : '0;
        din = '{pc: icache_addr, inst: icache_data[ILEN*sel +: ILEN]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            icache_addr <= RESET_PC;
            discard <= 1'b0;
        end else begin
            state <= state_next;
            pc <= pc_next;
            icache_addr <= hold ? icache_addr : pc_next;
            discard <= discard_next;
        end
    end
    fetch_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect_valid),
        .din(din), .head(head), .count(count)
    );
    assign icache_rqst = state == REQ;
    assign out_valid = count != '0;
    assign out_pc = head.pc;
    assign out_inst = head.inst;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a queue-based transaction model of the fetch unit
module tb_fetch_unit;
    localparam logic [63:0] RST_PC = 64'h400000;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;
    logic clk = 0;
    logic rst = 1, icache_done = 0, redirect_valid = 0, out_ready = 0;
    logic [63:0] redirect_pc = '0, icache_data;
    logic icache_rqst, out_valid;
    logic [63:0] icache_addr, out_pc, pc;
    logic [31:0] out_inst;
    int checks = 0, errors = 0;
    ent_t q[$];
    logic [63:0] m_pc = RST_PC, m_addr = RST_PC;
    bit m_busy = 0, m_drop = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .icache_rqst(icache_rqst), .icache_addr(icache_addr),
        .icache_done(icache_done), .icache_data(icache_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input logic [63:0] a);
        logic [63:0] w;
        w = a & ~64'h7;
        return {w[31:0] ^ w[63:32] ^ 32'hCAFEF00D, w[31:0] ^ w[63:32] ^ 32'h13579BDF};
    endfunction

    // Instruction at a byte address: the upper half of the word when the address sits in the second slot.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        logic [63:0] w;
        w = word_of(a);
        return (a % 8 == 4) ? w[63:32] : w[31:0];
    endfunction

    always_comb icache_data = word_of(icache_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input bit d, input bit r, input logic [63:0] rp, input bit rdy, input bit rs);
        bit dn, hold;
        logic [63:0] npc;
        if (rs) begin
            q.delete();
            m_pc = RST_PC;
            m_addr = RST_PC;
            m_busy = 0;
            m_drop = 0;
            return;
        end
        dn = m_busy && d;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (dn && !m_drop && !r) q.push_back('{pc: m_addr, inst: inst_of(m_addr)});
        if (r) q.delete();
        npc = r ? {rp[63:2], 2'b00} : (dn && !m_drop) ? m_pc + 64'd4 : m_pc;
        m_drop = (m_busy && !dn && r) ? 1'b1 : dn ? 1'b0 : m_drop;
        hold = m_busy && !dn;
        m_busy = hold || q.size() < 4;
        m_pc = npc;
        if (!hold) m_addr = npc;
    endtask

    task automatic cyc(input bit d, input bit r, input logic [63:0] rp, input bit rdy, input bit rs);
        icache_done = d;
        redirect_valid = r;
        redirect_pc = rp;
        out_ready = rdy;
        rst = rs;
        model(d, r, rp, rdy, rs);
        @(posedge clk);
        #1;
        chk("rqst", 64'(icache_rqst), 64'(m_busy));
        chk("pc", pc, m_pc);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (m_busy) chk("addr", icache_addr, m_addr);
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", 64'(out_inst), 64'(q[0].inst));
        end
    endtask

    initial begin
        #1;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_rqst", 64'(icache_rqst), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_addr", icache_addr, RST_PC);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", 64'(out_inst), 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        chk("full_rqst", 64'(icache_rqst), 0);
        chk("full_pc", pc, 64'h400010);
        chk("full_head", out_pc, 64'h400000);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(i % 3 == 2, 0, 0, 1'($urandom_range(0, 1)), 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 64'h80001002, 1, 0);
        chk("redir_hold_addr", icache_addr, RST_PC);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        chk("redir_new_addr", icache_addr, 64'h80001000);
        chk("redir_drop", 64'(out_valid), 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 64'h1234, 1, 0);
        chk("same_valid", 64'(out_valid), 0);
        chk("same_rqst", 64'(icache_rqst), 1);
        chk("same_addr", icache_addr, 64'h1234);
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("mid_rst_rqst", 64'(icache_rqst), 0);
        chk("mid_rst_valid", 64'(out_valid), 0);
        chk("mid_rst_pc", pc, RST_PC);
        cyc(1, 0, 0, 1, 0);
        chk("stray_done", 64'(out_valid), 0);
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 3) != 0),
                $urandom_range(0, 99) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the free-running PC incrementer.
- Drives the icache request/done handshake and tolerates variable icache latency.
- Buffers fetched instructions in a DEPTH-entry FIFO with valid/ready output towards decode.
- Supports redirects (branch/jump/trap), which flush the buffer and cancel any in-flight response.

Parameters:
- XLEN, 64: address width and icache data width.
- ILEN, 32: instruction width; XLEN/ILEN instructions per icache word.
- DEPTH, 4: fetch buffer entries, power of two, ≥2.
- RESET_PC, 64'h400000: fetch address after reset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- icache_rqst  out  1  request valid.
- icache_addr  out  XLEN  fetch address, ILEN/8-aligned.
- icache_done  in  1  response valid this cycle; only meaningful while icache_rqst=1.
- icache_data  in  XLEN  aligned XLEN-bit word containing icache_addr.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  XLEN  new fetch address; low log2(ILEN/8) bits ignored (forced 0).
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer accepts head.
- out_pc  out  XLEN  PC of head instruction.
- out_inst  out  ILEN  head instruction.
- pc  out  XLEN  next fetch address (debug/trace).

Behaviour:
- Reset: the cycle after rst is sampled high, the outputs are:
  - icache_rqst=0, out_valid=0, pc=RESET_PC, icache_addr=RESET_PC;
  - FIFO count=0, discard flag=0;
  - out_pc and out_inst are 0.
- rst dominates all other inputs, including a request in flight. Any icache_done arriving after reset is ignored, because rqst=0.
- FSM states:
  - IDLE: rqst=0.
  - REQ: rqst=1, addr=pc.
- IDLE→REQ when (count − pop_this_cycle) < DEPTH. The in-flight request reserves one slot, so the buffer never overflows.
- REQ→REQ or REQ→IDLE on icache_done, evaluated with the same space rule using the post-update count. This allows back-to-back requests with zero bubble.
- Handshake rule: while rqst=1 without done, icache_addr is held stable, including across redirects.
- On done:
  - the response is pushed unless discard=1;
  - the instruction is selected as icache_data[ILEN*addr[log2(XLEN/8)-1:log2(ILEN/8)] +: ILEN];
  - pc += ILEN/8, wrapping modulo 2^XLEN.
- Latency: done in cycle t → out_valid=1 with that instruction in t+1.
- Pop: when out_valid && out_ready; FIFO order is preserved.
- Push and pop in the same cycle: count is unchanged. A push into a full FIFO cannot occur, by construction.
- Redirect (redirect_valid=1 in cycle t):
  - FIFO flushed, so out_valid=0 in t+1 and any pop in t is still discarded;
  - pc=redirect_pc in t+1.
  - If REQ and no done in t: discard:=1, and rqst/addr stay at the old pc until done. That response is dropped, then discard:=0, and a request to the new pc issues in the next cycle.
  - If done in t: the response is dropped, and REQ at redirect_pc in t+1.
  - If IDLE: REQ at redirect_pc in t+1.
- A second redirect while discard=1 overwrites pc; only the last redirect target is fetched.

Decomposition:
- fetch_pkg holds:
  - defaults XLEN_D=64, ILEN_D=32, RESET_PC_D;
  - typedef fetch_state_e {IDLE, REQ};
  - typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo:
  - parametrised width/DEPTH synchronous FIFO with push, pop, flush, count, head;
  - flush has priority over push and pop.

Test Plan:
- Reset, then icache_done every cycle, out_ready=1 → addresses 400000, 400004, 400008…; out_inst alternates low/high word of icache_data; out_pc matches; one instruction per cycle after 2-cycle start-up.
- out_ready=0, done always 1 → exactly DEPTH=4 entries buffered; rqst=0 afterwards; pc=400010. Raising out_ready → entries 400000–40000C drain in order, then fetch resumes at 400010.
- Icache latency 3 cycles → icache_addr stable for all 3 cycles; one push per response.
- Redirect to 0x80001002 while a request is pending without done → addr unchanged until done; that response is dropped; next rqst addr=0x80001000; first out_pc=0x80001000.
- Redirect in the same cycle as done and out_ready → no stale entry appears; out_valid=0 next cycle; rqst at the target next cycle.
- rst asserted mid-stream with a request pending → next cycle rqst=0, out_valid=0, pc=400000; a later stray done causes no push.
